prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 90 +++++++++
 tb/tb_prog_loader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: streams a host program into instruction memory, launches the core and times its run.
module prog_loader #(
  parameter int AW = 10,
  parameter int START_CYC = 2,
  parameter logic [8:0] DONE_WORD = 9'h1FF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          InValid,
  input  logic [8:0]    InData,
  output logic          InReady,
  output logic          IWrEn,
  output logic [AW-1:0] IWrAddr,
  output logic [8:0]    IWrData,
  output logic          Start,
  input  logic          Ack,
  input  logic          Clear,
  output logic          Done,
  output logic          Err,
  output logic [AW:0]   ProgLen,
  output logic [15:0]   RunCycles
);
  typedef enum logic [2:0] {LOAD, LAUNCH, RUN, DONE, ERR} state_t;
  state_t state;
  logic [AW-1:0] waddr;
  logic [3:0] cnt;
  logic acc;
  // InReady is registered and only ever high in LOAD, so acceptance implies LOAD
  assign acc = InValid & InReady;
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= LOAD;
      InReady <= 1'b0;
      IWrEn <= 1'b0;
      IWrAddr <= '0;
      IWrData <= '0;
      Start <= 1'b1;
      Done <= 1'b0;
      Err <= 1'b0;
      ProgLen <= '0;
      RunCycles <= '0;
      waddr <= '0;
      cnt <= '0;
    end else begin
      IWrEn <= acc;
      if (acc) begin
        IWrAddr <= waddr;
        IWrData <= InData;
        waddr <= waddr + 1'b1;
        ProgLen <= ProgLen + 1'b1;
      end
      case (state)
        LOAD:
          if (acc && InData == DONE_WORD) begin
            state <= LAUNCH;
            InReady <= 1'b0;
            cnt <= 4'(START_CYC - 1);
            RunCycles <= '0;
          end else if (acc && &waddr) begin
            state <= ERR;
            InReady <= 1'b0;
            Err <= 1'b1;
          end else InReady <= 1'b1;
        LAUNCH:
          if (cnt == '0) begin
            state <= RUN;
            Start <= 1'b0;
          end else cnt <= cnt - 1'b1;
        RUN: begin
          if (~&RunCycles) RunCycles <= RunCycles + 1'b1;
          if (Ack) begin
            state <= DONE;
            Done <= 1'b1;
            Start <= 1'b1;
          end
        end
        DONE, ERR:
          if (Clear) begin
            state <= LOAD;
            InReady <= 1'b1;
            Done <= 1'b0;
            Err <= 1'b0;
            ProgLen <= '0;
            waddr <= '0;
          end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vectors for the loader at default width plus a 3-bit-address instance for overflow.
module tb_prog_loader;
  logic clk = 1'b0;
  logic rst_n, inv, ack, clr;
  logic [8:0] d;
  logic rdy0, wen0, st0, dn0, er0;
  logic [9:0] addr0;
  logic [8:0] data0;
  logic [10:0] plen0;
  logic [15:0] run0;
  logic rdy1, wen1, st1, dn1, er1;
  logic [2:0] addr1;
  logic [8:0] data1;
  logic [3:0] plen1;
  logic [15:0] run1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  prog_loader u0 (
    .Clk(clk), .Reset(rst_n), .InValid(inv), .InData(d), .InReady(rdy0), .IWrEn(wen0),
    .IWrAddr(addr0), .IWrData(data0), .Start(st0), .Ack(ack), .Clear(clr), .Done(dn0),
    .Err(er0), .ProgLen(plen0), .RunCycles(run0)
  );

  prog_loader #(.AW(3)) u1 (
    .Clk(clk), .Reset(rst_n), .InValid(inv), .InData(d), .InReady(rdy1), .IWrEn(wen1),
    .IWrAddr(addr1), .IWrData(data1), .Start(st1), .Ack(ack), .Clear(clr), .Done(dn1),
    .Err(er1), .ProgLen(plen1), .RunCycles(run1)
  );

  typedef struct {
    logic inv;
    logic [8:0] d;
    logic ack;
    logic clr;
    logic rdy;
    logic wen;
    logic [9:0] addr;
    logic [8:0] data;
    logic st;
    logic dn;
    logic [10:0] plen;
  } vec_t;

  vec_t v[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    v[0] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 9'h000, 1'b1, 1'b0, 11'd0};
    v[1] = '{1'b1, 9'h041, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 9'h041, 1'b1, 1'b0, 11'd1};
    v[2] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 9'h000, 1'b1, 1'b0, 11'd1};
    v[3] = '{1'b1, 9'h032, 1'b0, 1'b0, 1'b1, 1'b1, 10'd1, 9'h032, 1'b1, 1'b0, 11'd2};
    v[4] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 9'h000, 1'b1, 1'b0, 11'd2};
    v[5] = '{1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b1, 10'd2, 9'h1FF, 1'b1, 1'b0, 11'd3};
    v[6] = '{1'b1, 9'h055, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 9'h000, 1'b1, 1'b0, 11'd3};
    v[7] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 9'h000, 1'b0, 1'b0, 11'd3};
    v[8] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 9'h000, 1'b0, 1'b0, 11'd3};
    rst_n = 1'b0; inv = 1'b0; d = '0; ack = 1'b0; clr = 1'b0;
    repeat (2) step();
    chk("reset rdy", rdy0, 0);
    chk("reset wen", wen0, 0);
    chk("reset start", st0, 1);
    chk("reset plen", plen0, 0);
    chk("reset run", run0, 0);
    chk("reset err", er0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      inv = v[i].inv; d = v[i].d; ack = v[i].ack; clr = v[i].clr;
      step();
      chk($sformatf("v%0d rdy", i), rdy0, v[i].rdy);
      chk($sformatf("v%0d wen", i), wen0, v[i].wen);
      chk($sformatf("v%0d start", i), st0, v[i].st);
      chk($sformatf("v%0d done", i), dn0, v[i].dn);
      chk($sformatf("v%0d plen", i), plen0, v[i].plen);
      if (v[i].wen) begin
        chk($sformatf("v%0d addr", i), addr0, v[i].addr);
        chk($sformatf("v%0d data", i), data0, v[i].data);
      end
    end
    chk("run first", run0, 1);
    repeat (48) step();
    chk("run 49", run0, 49);
    chk("run start low", st0, 0);
    ack = 1'b1;
    step();
    chk("ack done", dn0, 1);
    chk("ack start", st0, 1);
    chk("ack run", run0, 50);
    repeat (3) step();
    chk("run frozen", run0, 50);
    chk("done held", dn0, 1);
    chk("done rdy", rdy0, 0);
    ack = 1'b0; inv = 1'b1; d = 9'h0AA; clr = 1'b1;
    step();
    chk("clear rdy", rdy0, 1);
    chk("clear no write", wen0, 0);
    chk("clear done", dn0, 0);
    chk("clear plen", plen0, 0);
    clr = 1'b0; d = 9'h1FF;
    step();
    chk("reload wen", wen0, 1);
    chk("reload addr", addr0, 0);
    chk("reload data", data0, 9'h1FF);
    chk("reload plen", plen0, 1);
    inv = 1'b0;
    repeat (5) step();
    chk("rerun start", st0, 0);
    chk("rerun run", run0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async start", st0, 1);
    chk("async rdy", rdy0, 0);
    chk("async plen", plen0, 0);
    chk("async run", run0, 0);
    chk("async done", dn0, 0);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("post reset rdy", rdy0, 1);
    inv = 1'b1; d = 9'h007;
    step();
    chk("post reset wen", wen0, 1);
    chk("post reset addr", addr0, 0);
    chk("post reset data", data0, 9'h007);
    chk("post reset plen", plen0, 1);
    inv = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      inv = 1'b1; d = 9'(i);
      step();
      chk($sformatf("ovf w%0d addr", i), addr1, i);
      if (i < 7) chk($sformatf("ovf w%0d err", i), er1, 0);
    end
    chk("ovf err", er1, 1);
    chk("ovf wen", wen1, 1);
    chk("ovf data", data1, 7);
    chk("ovf rdy", rdy1, 0);
    chk("ovf start", st1, 1);
    chk("ovf plen", plen1, 8);
    d = 9'h1FF;
    step();
    chk("err no write", wen1, 0);
    chk("err held", er1, 1);
    inv = 1'b0; clr = 1'b1;
    step();
    chk("err clear", er1, 0);
    chk("err clear plen", plen1, 0);
    chk("err clear rdy", rdy1, 1);
    clr = 1'b0; inv = 1'b1; d = 9'h033;
    step();
    chk("err reload addr", addr1, 0);
    chk("err reload data", data1, 9'h033);
    chk("err reload plen", plen1, 1);
    inv = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
